// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - shared encodings for the multicycle controller
// State, opcode, aluOp and pcSrc codes plus the packed control word.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ANDI  = 4'h2;
  localparam logic [3:0] OP_ORI   = 4'h3;
  localparam logic [3:0] OP_LW    = 4'h4;
  localparam logic [3:0] OP_SW    = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Must stay in step with ALUControl in the Execute stage.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;

  localparam logic [1:0] PC_PLUS1  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic is_illegal(input logic [3:0] op);
    return op[3] && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/mcu_output_decode.sv
// rtl/mcu_output_decode.sv - combinational state + opcode to control-word table
module mcu_output_decode
  import multicycle_control_unit_pkg::*;
(
  input  logic [2:0]        state_i,
  input  logic [3:0]        opcode_i,
  input  logic              zero_i,
  input  logic              mem_ready_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  state_e st;
  ctrl_t  c;

  assign st     = state_e'(state_i);
  assign ctrl_o = c;

  always_comb begin
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_read = 1'b1;
        if (mem_ready_i) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          c.pc_src   = PC_PLUS1;
        end
      end
      ST_DECODE: c.illegal = is_illegal(opcode_i);
      ST_EXEC: begin
        case (opcode_i)
          OP_RTYPE: c.alu_op = ALU_FUNC;
          OP_ADDI:  begin c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
          OP_ANDI:  begin c.alu_src = 1'b1; c.alu_op = ALU_AND; end
          OP_ORI:   begin c.alu_src = 1'b1; c.alu_op = ALU_OR;  end
          OP_LW, OP_SW: begin c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
          OP_BEQ: begin
            c.alu_op   = ALU_SUB;
            c.pc_src   = PC_BRANCH;
            c.pc_write = zero_i;
          end
          OP_JMP: begin
            c.pc_src   = PC_JUMP;
            c.pc_write = 1'b1;
          end
          default: ;
        endcase
      end
      // Strobe is held through wait cycles; the FSM decides when to leave.
      ST_MEM: begin
        c.mem_read  = (opcode_i == OP_LW);
        c.mem_write = (opcode_i == OP_SW);
      end
      ST_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = (opcode_i == OP_LW);
        c.reg_dst    = (opcode_i == OP_RTYPE);
      end
      ST_HALT: c.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore FSM sequencing the multicycle datapath
// Optional retire counter under RETIRE_COUNTER_EN.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int SINGLE_CYCLE_MEM = 0
) (
  input  logic        inp_clk,
  input  logic        inp_reset,
  input  logic [15:0] inp_instr,
  input  logic        inp_zero,
  input  logic        inp_memReady,
  output logic        out_pcWrite,
  output logic [1:0]  out_pcSrc,
  output logic        out_irWrite,
  output logic        out_memRead,
  output logic        out_memWrite,
  output logic        out_regWrite,
  output logic        out_memToReg,
  output logic        out_regDst,
  output logic        out_aluSrc,
  output logic [2:0]  out_aluOp,
  output logic [2:0]  out_state,
`ifdef RETIRE_COUNTER_EN
  output logic [15:0] out_retired,
`endif
  output logic        out_halted,
  output logic        out_illegal
);

  state_e            state_q, state_d;
  logic [3:0]        opcode;
  logic              mem_ready;
  logic [CTRL_W-1:0] dec_word;
  ctrl_t             ctrl;
  logic              unused_instr_bits;

  assign opcode            = inp_instr[15:12];
  assign mem_ready         = (SINGLE_CYCLE_MEM != 0) || inp_memReady;
  assign unused_instr_bits = ^inp_instr[11:0];

  always_ff @(posedge inp_clk) begin
    if (inp_reset) state_q <= ST_FETCH;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (opcode == OP_HALT)       state_d = ST_HALT;
        else if (is_illegal(opcode)) state_d = ST_FETCH;
        else                         state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = ST_MEM;
          OP_BEQ, OP_JMP: state_d = ST_FETCH;
          default:        state_d = ST_WB;
        endcase
      end
      ST_MEM:  if (mem_ready) state_d = (opcode == OP_LW) ? ST_WB : ST_FETCH;
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  mcu_output_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .zero_i      (inp_zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (dec_word)
  );

  // Reset masks every strobe so an aborted instruction issues no partial write.
  assign ctrl         = inp_reset ? '0 : ctrl_t'(dec_word);
  assign out_state    = inp_reset ? 3'd0 : state_q;
  assign out_pcWrite  = ctrl.pc_write;
  assign out_pcSrc    = ctrl.pc_src;
  assign out_irWrite  = ctrl.ir_write;
  assign out_memRead  = ctrl.mem_read;
  assign out_memWrite = ctrl.mem_write;
  assign out_regWrite = ctrl.reg_write;
  assign out_memToReg = ctrl.mem_to_reg;
  assign out_regDst   = ctrl.reg_dst;
  assign out_aluSrc   = ctrl.alu_src;
  assign out_aluOp    = ctrl.alu_op;
  assign out_halted   = ctrl.halted;
  assign out_illegal  = ctrl.illegal;

`ifdef RETIRE_COUNTER_EN
  logic [15:0] retired_q;
  logic        retire_evt;

  // Only EXEC, MEM and WB can hand back to FETCH from outside FETCH except DECODE.
  assign retire_evt = (state_d == ST_FETCH) &&
                      (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB);

  always_ff @(posedge inp_clk) begin
    if (inp_reset)       retired_q <= 16'd0;
    else if (retire_evt) retired_q <= retired_q + 16'd1;
  end

  assign out_retired = inp_reset ? 16'd0 : retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg_dst, alu_src;
  logic        halted, illegal;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op, state;
`ifdef RETIRE_COUNTER_EN
  logic [15:0] retired;
`endif

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .inp_clk      (clk),
    .inp_reset    (rst),
    .inp_instr    (instr),
    .inp_zero     (zero),
    .inp_memReady (mem_ready),
    .out_pcWrite  (pc_write),
    .out_pcSrc    (pc_src),
    .out_irWrite  (ir_write),
    .out_memRead  (mem_read),
    .out_memWrite (mem_write),
    .out_regWrite (reg_write),
    .out_memToReg (mem_to_reg),
    .out_regDst   (reg_dst),
    .out_aluSrc   (alu_src),
    .out_aluOp    (alu_op),
    .out_state    (state),
`ifdef RETIRE_COUNTER_EN
    .out_retired  (retired),
`endif
    .out_halted   (halted),
    .out_illegal  (illegal)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       hlt, ill, pcw;
    logic [1:0] pcs;
    logic       irw, mrd, mwr, rgw, m2r, rdst, asrc;
    logic [2:0] aop;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  bit          rdy_q[$];
  logic [15:0] retire_model = 16'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t sample();
    exp_t o;
    o.st = state; o.hlt = halted; o.ill = illegal; o.pcw = pc_write; o.pcs = pc_src;
    o.irw = ir_write; o.mrd = mem_read; o.mwr = mem_write; o.rgw = reg_write;
    o.m2r = mem_to_reg; o.rdst = reg_dst; o.asrc = alu_src; o.aop = alu_op;
    return o;
  endfunction

  task automatic add(input exp_t e, input bit r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endtask

  // Expected per-cycle control trace of one instruction, by instruction class.
  task automatic plan(input logic [15:0] ins, input int fw, input int mw, input bit z);
    exp_t       e;
    logic [3:0] op;
    op = ins[15:12];
    e = '0; e.mrd = 1'b1;
    for (int i = 0; i < fw; i++) add(e, 1'b0);
    e.irw = 1'b1; e.pcw = 1'b1; e.pcs = 2'b00;
    add(e, 1'b1);
    e = '0; e.st = 3'd1; e.ill = (op >= 4'h8 && op <= 4'hE);
    add(e, 1'($urandom_range(0, 1)));
    if (op >= 4'h8) return;
    e = '0; e.st = 3'd2;
    case (op)
      4'h0: e.aop = 3'b010;
      4'h1: begin e.asrc = 1'b1; e.aop = 3'b000; end
      4'h2: begin e.asrc = 1'b1; e.aop = 3'b011; end
      4'h3: begin e.asrc = 1'b1; e.aop = 3'b100; end
      4'h4, 4'h5: begin e.asrc = 1'b1; e.aop = 3'b000; end
      4'h6: begin e.aop = 3'b001; e.pcs = 2'b01; e.pcw = z; end
      default: begin e.pcs = 2'b10; e.pcw = 1'b1; end
    endcase
    add(e, 1'($urandom_range(0, 1)));
    if (op == 4'h4 || op == 4'h5) begin
      e = '0; e.st = 3'd3; e.mrd = (op == 4'h4); e.mwr = (op == 4'h5);
      for (int i = 0; i < mw; i++) add(e, 1'b0);
      add(e, 1'b1);
    end
    if (op <= 4'h4) begin
      e = '0; e.st = 3'd4; e.rgw = 1'b1; e.m2r = (op == 4'h4); e.rdst = (op == 4'h0);
      add(e, 1'($urandom_range(0, 1)));
    end
    retire_model = retire_model + 16'd1;
  endtask

  task automatic step(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    mem_ready = rdy_q.pop_front();
    #1;
    check(tag, 32'(sample()), 32'(e));
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input logic [15:0] ins, input int fw, input int mw, input bit z);
    instr = ins; zero = z;
    plan(ins, fw, mw, z);
    while (exp_q.size() > 0) step(tag);
`ifdef RETIRE_COUNTER_EN
    check({tag, "_retired"}, 32'(retired), 32'(retire_model));
`endif
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check(tag, 32'(sample()), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    retire_model = 16'd0;
  endtask

  task automatic run_halt(input string tag, input int fw);
    exp_t e;
    instr = 16'hF000; zero = 1'b0;
    plan(16'hF000, fw, 0, 1'b0);
    while (exp_q.size() > 0) step(tag);
    e = '0; e.st = 3'd5; e.hlt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check({tag, "_halted"}, 32'(sample()), 32'(e));
      @(posedge clk); #1;
    end
    do_reset({tag, "_reset"}, 1);
  endtask

  initial begin
    logic [15:0] ins;
    int          kind;
    rst = 1'b1; instr = 16'h0123; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    do_reset("reset", 2);

    run("rtype", 16'h0123, 0, 0, 1'b0);
    run("lw_wait", 16'h4125, 0, 3, 1'b0);
    run("beq_taken", 16'h6124, 0, 0, 1'b1);
    run("beq_not", 16'h6124, 0, 0, 1'b0);
    run("illegal", 16'h9000, 0, 0, 1'b0);
    run("addi_fw", 16'h1FFF, 2, 0, 1'b0);
    run("sw", 16'h5321, 1, 2, 1'b1);
    run("jmp", 16'h7ABC, 0, 0, 1'b1);
    run("ori", 16'h3001, 0, 0, 1'b0);
    run("andi", 16'h2001, 0, 0, 1'b0);
    run("illegal_e", 16'hE123, 1, 0, 1'b0);

`ifdef RETIRE_COUNTER_EN
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    retire_model = 16'hFFFF;
    run("wrap_addi", 16'h1005, 0, 0, 1'b0);
`endif

    // SW aborted by reset while its write strobe is waiting in MEM.
    instr = 16'h5777; zero = 1'b0;
    plan(16'h5777, 0, 6, 1'b0);
    for (int i = 0; i < 5; i++) step("sw_abort");
    exp_q.delete(); rdy_q.delete();
    do_reset("sw_abort_rst", 1);
    run("after_abort", 16'h0456, 0, 0, 1'b0);

    run_halt("halt", 1);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 19);
      ins  = 16'($urandom);
      if (kind == 0) begin
        run_halt("rnd_halt", $urandom_range(0, 2));
      end else begin
        if (kind < 17) ins[15:12] = 4'($urandom_range(0, 7));
        else           ins[15:12] = 4'($urandom_range(8, 14));
        run("rnd", ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style main controller that sequences the 16-bit RISC datapath over multiple cycles: fetch, decode, execute, memory, writeback.
- Per state, drives the Execute stage controls (aluSrc, aluOp), plus PC, IR, register-file and memory enables.
- Consumes the ALU zero flag for branches and a memory ready handshake.
- Sits at top level beside the datapath; the only source of control strobes.

Parameters:
- SINGLE_CYCLE_MEM, default 0: 1 treats memory as always ready; inp_memReady is ignored.

Ports:
- inp_clk  input  1  system clock (rising edge)
- inp_reset  input  1  synchronous, active-high reset
- inp_instr  input  16  current IR contents; opcode = [15:12], func = [3:0]
- inp_zero  input  1  ALU zero flag from Execute
- inp_memReady  input  1  memory access complete this cycle
- out_pcWrite  output  1  PC load enable
- out_pcSrc  output  2  00 = PC+1, 01 = branch target, 10 = jump target
- out_irWrite  output  1  IR load enable
- out_memRead  output  1  memory read strobe
- out_memWrite  output  1  memory write strobe
- out_regWrite  output  1  register-file write enable
- out_memToReg  output  1  writeback source: 1 = memory, 0 = ALU
- out_regDst  output  1  destination register: 1 = rd (R-type), 0 = rt
- out_aluSrc  output  1  to Execute: 1 = immediate
- out_aluOp  output  3  to Execute: 000 ADD, 001 SUB, 010 use func, 011 AND, 100 OR
- out_state  output  3  current state, for debug
- out_halted  output  1  high in HALT
- out_illegal  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5.
- State register is updated only on the inp_clk rising edge. Outputs decode combinationally from state and opcode.
- While inp_reset = 1: next state = FETCH, and every output is forced to 0 (out_state reads 0).
- Reset mid-instruction aborts it. No partial write is issued in the reset cycle.
- FETCH:
  - memRead = 1.
  - Waits while inp_memReady = 0; all strobes other than memRead stay 0 while waiting.
  - The ready cycle asserts irWrite = 1 and pcWrite = 1 with pcSrc = 00, then goes to DECODE.
- DECODE:
  - No strobes.
  - Opcode 1111 goes to HALT.
  - An undefined opcode (1000–1110) pulses out_illegal and returns to FETCH.
  - All other opcodes go to EXEC.
- EXEC, by opcode:
  - 0000 R-type: aluSrc = 0, aluOp = 010 -> WB.
  - 0001 ADDI: aluSrc = 1, aluOp = 000 -> WB.
  - 0010 ANDI: aluSrc = 1, aluOp = 011 -> WB.
  - 0011 ORI: aluSrc = 1, aluOp = 100 -> WB.
  - 0100 LW and 0101 SW: aluSrc = 1, aluOp = 000 -> MEM.
  - 0110 BEQ: aluSrc = 0, aluOp = 001, pcSrc = 01, pcWrite = inp_zero -> FETCH.
  - 0111 JMP: pcSrc = 10, pcWrite = 1 -> FETCH.
- MEM:
  - LW asserts memRead; SW asserts memWrite.
  - The strobe is held until inp_memReady = 1.
  - LW -> WB; SW -> FETCH.
- WB:
  - regWrite = 1.
  - memToReg = 1 only for LW.
  - regDst = 1 only for R-type.
  - Always -> FETCH.
- HALT: absorbing; out_halted = 1, all strobes 0. Exits only on reset.
- Latency in cycles at zero wait:
  - R-type and I-type ALU: 4
  - LW: 5
  - SW: 4
  - BEQ and JMP: 3
  - illegal: 2
  - Each memory wait cycle adds 1.
- Any output not listed for a state is 0.
- With SINGLE_CYCLE_MEM = 1, FETCH and MEM always take exactly 1 cycle.

Optional Feature:
- Macro RETIRE_COUNTER_EN.
- Defined:
  - Adds output out_retired[15:0].
  - Increments by 1 in each cycle the FSM transitions into FETCH from EXEC, MEM or WB.
  - Wraps from 0xFFFF to 0x0000.
  - Cleared by reset.
  - Illegal opcodes and HALT do not count.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encodings;
  - opcode constants (OP_RTYPE … OP_HALT);
  - aluOp encodings, which must match ALUControl;
  - pcSrc encodings.
- One natural sub-module: mcu_output_decode, the combinational state + opcode -> control-word table.
- The FSM and optional counter stay in the top module.

Test Plan:
- Reset held 2 cycles with inp_instr = 0x0123 -> all outputs 0. After release, cycle 0 is FETCH with memRead = 1.
- R-type 0x0123, memReady tied 1 -> states 0,1,2,4,0. In EXEC aluOp = 010, aluSrc = 0. In WB regWrite = 1, regDst = 1. Retire count = 1.
- LW 0x4125 with memReady low 3 cycles in MEM -> memRead held 4 cycles. WB has memToReg = 1, regDst = 0. Total 8 cycles.
- BEQ 0x6124, first with inp_zero = 1, then with inp_zero = 0 -> pcWrite = 1, pcSrc = 01 in EXEC for the first; pcWrite = 0 for the second. Both take 3 cycles.
- Opcode 0x9000 -> out_illegal pulses 1 cycle in DECODE, then FETCH; retire count unchanged. Opcode 0xF000 -> HALT with out_halted = 1 indefinitely until reset.
- Under RETIRE_COUNTER_EN, force the counter to 0xFFFF and retire one ADDI -> out_retired = 0x0000. Assert reset mid-MEM of SW -> memWrite = 0 that cycle, FSM restarts at FETCH.
